// File: rtl/data_sram_resp.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_resp
// Brief    : Data-SRAM responder: word RAM plus LED/counter/TX-FIFO MMIO.
// Revision : 1.0
// ============================================================================
module data_sram_resp #(
  parameter int RAM_AW     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [13:0] c_LED_WORD = 14'h3c00;
  localparam logic [13:0] c_CNT_WORD = 14'h3c04;
  localparam logic [13:0] c_TXD_WORD = 14'h3c08;
  localparam logic [13:0] c_TXS_WORD = 14'h3c09;

  logic [31:0]       r_ram [2**RAM_AW];
  logic [7:0]        r_buf [FIFO_DEPTH];
  logic [15:0]       r_led;
  logic [31:0]       r_cycles;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic              r_ovf;

  logic              w_is_mmio;
  logic [13:0]       w_word;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_empty;
  logic              w_full;
  logic              w_wr_led;
  logic              w_wr_cnt;
  logic              w_wr_txd;
  logic              w_wr_txs;
  logic              w_pop;
  logic              w_push_ok;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_is_mmio = (data_sram_addr[31:16] == 16'hbfaf);
  assign w_word    = data_sram_addr[15:2];
  assign w_ram_idx = data_sram_addr[RAM_AW+1:2];
  assign w_unused  = &{1'b0, data_sram_addr[1:0]};

  assign w_wr_led = data_sram_we & w_is_mmio & (w_word == c_LED_WORD);
  assign w_wr_cnt = data_sram_we & w_is_mmio & (w_word == c_CNT_WORD);
  assign w_wr_txd = data_sram_we & w_is_mmio & (w_word == c_TXD_WORD);
  assign w_wr_txs = data_sram_we & w_is_mmio & (w_word == c_TXS_WORD);

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = tx_valid & tx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push_ok = w_wr_txd & (~w_full | w_pop);

  assign led      = r_led;
  assign tx_valid = ~w_empty;
  assign tx_data  = w_empty ? 8'h00 : r_buf[r_rd_ptr];

  always_comb begin
    w_rdata = '0;
    if (w_is_mmio) begin
      case (w_word)
        c_LED_WORD: w_rdata = {16'b0, r_led};
        c_CNT_WORD: w_rdata = r_cycles;
        c_TXS_WORD: w_rdata = {29'b0, r_ovf, w_full, w_empty};
        default:    w_rdata = '0;
      endcase
    end else begin
      w_rdata = r_ram[w_ram_idx];
    end
  end

  assign data_sram_rdata = w_rdata;

  // Storage arrays carry no reset: RAM survives reset, FIFO slots are masked by count.
  always_ff @(posedge clk) begin
    if (data_sram_we && !w_is_mmio) begin
      r_ram[w_ram_idx] <= data_sram_wdata;
    end
    if (w_push_ok) begin
      r_buf[r_wr_ptr] <= data_sram_wdata[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led    <= '0;
      r_cycles <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_led) begin
        r_led <= data_sram_wdata[15:0];
      end
      r_cycles <= w_wr_cnt ? 32'd0 : r_cycles + 32'd1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
      // A dropped push outranks a status-clear write in the same cycle.
      if (w_wr_txd && !w_push_ok) begin
        r_ovf <= 1'b1;
      end else if (w_wr_txs) begin
        r_ovf <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_sram_resp
// Brief    : Self-checking bench: vector table, directed corners, random vs model.
// Revision : 1.0
// ============================================================================
module tb_data_sram_resp;

  localparam int RAM_AW = 10;
  localparam int DEPTH  = 4;
  localparam logic [31:0] A_LED = 32'hbfaff000;
  localparam logic [31:0] A_CNT = 32'hbfaff010;
  localparam logic [31:0] A_TXD = 32'hbfaff020;
  localparam logic [31:0] A_TXS = 32'hbfaff024;
  localparam logic [31:0] A_UNM = 32'hbfaff100;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] led;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  data_sram_resp #(.RAM_AW(RAM_AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .led             (led),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_data         (tx_data)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_mem [int];
  logic [15:0] m_led;
  logic [31:0] m_cnt;
  logic [7:0]  m_q [$];
  logic        m_ovf;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
    logic        exp_valid;
    logic [7:0]  exp_data;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit sel(input logic [31:0] a, input logic [31:0] reg_a);
    return (a[31:16] == 16'hbfaf) && (a[15:2] == reg_a[15:2]);
  endfunction

  task automatic model_reset();
    m_led = '0;
    m_cnt = '0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
    known = 1'b1;
    v = '0;
    if (a[31:16] == 16'hbfaf) begin
      if (sel(a, A_LED))      v = {16'b0, m_led};
      else if (sel(a, A_CNT)) v = m_cnt;
      else if (sel(a, A_TXS)) v = {29'b0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
    end else if (m_mem.exists(int'(a[RAM_AW+1:2]))) begin
      v = m_mem[int'(a[RAM_AW+1:2])];
    end else begin
      known = 1'b0;
    end
  endtask

  task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
    bit pop, push, acc;
    pop  = (m_q.size() > 0) && r;
    push = w && sel(a, A_TXD);
    acc  = push && ((m_q.size() < DEPTH) || pop);
    if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back(d[7:0]);
    if (push && !acc) m_ovf = 1'b1;
    else if (w && sel(a, A_TXS)) m_ovf = 1'b0;
    m_cnt = (w && sel(a, A_CNT)) ? 32'd0 : m_cnt + 32'd1;
    if (w && sel(a, A_LED)) m_led = d[15:0];
    if (w && a[31:16] != 16'hbfaf) m_mem[int'(a[RAM_AW+1:2])] = d;
  endtask

  // Called just after an edge: drive inputs, let them settle, check against the model.
  task automatic drive_check(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
    logic [31:0] v;
    bit known;
    we = w; addr = a; wdata = d; tx_ready = r;
    #3;
    model_read(a, v, known);
    if (known) chk("model_rdata", rdata, v);
    chk("model_led", {16'b0, led}, {16'b0, m_led});
    chk("model_valid", {31'b0, tx_valid}, {31'b0, m_q.size() != 0});
    chk("model_data", {24'b0, tx_data}, {24'b0, (m_q.size() != 0) ? m_q[0] : 8'h00});
  endtask

  task automatic clock_step();
    @(posedge clk);
    if (!reset) model_step(we, addr, wdata, tx_ready);
    #1;
  endtask

  vec_t vt [$];

  task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r,
                     input logic c, input logic [31:0] er, input logic [15:0] el,
                     input logic ev, input logic [7:0] ed);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.ready = r; v.chk_rd = c;
    v.exp_rd = er; v.exp_led = el; v.exp_valid = ev; v.exp_data = ed;
    vt.push_back(v);
  endtask

  initial begin
    logic [31:0] c1;
    logic [7:0]  got [$];
    int          guard;

    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; tx_ready = 1'b0;
    model_reset();
    #3;
    chk("reset_led", {16'b0, led}, 32'h0);
    chk("reset_valid", {31'b0, tx_valid}, 32'h0);
    chk("reset_data", {24'b0, tx_data}, 32'h0);
    addr = A_TXS; #1;
    chk("reset_txs", rdata, 32'h1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Vector table: {we, addr, wdata, ready, check_rd, exp_rd, exp_led, exp_valid, exp_data}
    add(1, 32'h100, 32'h12345678, 0, 0, 0,            16'h0,    0, 8'h00);
    add(1, 32'h104, 32'hdeadbeef, 0, 0, 0,            16'h0,    0, 8'h00);
    add(0, 32'h100, 0,            0, 1, 32'h12345678, 16'h0,    0, 8'h00);
    add(0, 32'h104, 0,            0, 1, 32'hdeadbeef, 16'h0,    0, 8'h00);
    add(0, 32'h102, 0,            0, 1, 32'h12345678, 16'h0,    0, 8'h00);
    add(1, A_LED,   32'hffffabcd, 0, 0, 0,            16'h0,    0, 8'h00);
    add(0, A_LED,   0,            0, 1, 32'h0000abcd, 16'habcd, 0, 8'h00);
    add(1, A_TXD,   32'h11,       0, 0, 0,            16'habcd, 0, 8'h00);
    add(1, A_TXD,   32'h22,       0, 0, 0,            16'habcd, 1, 8'h11);
    add(1, A_TXD,   32'h33,       0, 0, 0,            16'habcd, 1, 8'h11);
    add(1, A_TXD,   32'h44,       0, 1, 32'h0,        16'habcd, 1, 8'h11);
    add(1, A_TXD,   32'h55,       0, 1, 32'h0,        16'habcd, 1, 8'h11);
    add(0, A_TXS,   0,            0, 1, 32'h6,        16'habcd, 1, 8'h11);
    add(0, A_TXS,   0,            1, 1, 32'h6,        16'habcd, 1, 8'h11);
    add(0, A_TXS,   0,            1, 1, 32'h4,        16'habcd, 1, 8'h22);
    add(0, A_TXS,   0,            1, 1, 32'h4,        16'habcd, 1, 8'h33);
    add(0, A_TXS,   0,            1, 1, 32'h4,        16'habcd, 1, 8'h44);
    add(0, A_TXS,   0,            1, 1, 32'h5,        16'habcd, 0, 8'h00);
    add(1, A_TXS,   0,            1, 1, 32'h5,        16'habcd, 0, 8'h00);
    add(0, A_TXS,   0,            0, 1, 32'h1,        16'habcd, 0, 8'h00);
    add(1, A_UNM,   32'hffffffff, 0, 1, 32'h0,        16'habcd, 0, 8'h00);
    add(0, A_UNM,   0,            0, 1, 32'h0,        16'habcd, 0, 8'h00);
    add(0, A_LED,   0,            0, 1, 32'h0000abcd, 16'habcd, 0, 8'h00);

    foreach (vt[i]) begin
      drive_check(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].ready);
      if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rdata, vt[i].exp_rd);
      chk($sformatf("vec%0d_led", i), {16'b0, led}, {16'b0, vt[i].exp_led});
      chk($sformatf("vec%0d_valid", i), {31'b0, tx_valid}, {31'b0, vt[i].exp_valid});
      chk($sformatf("vec%0d_data", i), {24'b0, tx_data}, {24'b0, vt[i].exp_data});
      clock_step();
    end

    // Counter: 5-cycle difference, then write-clears-and-wins.
    drive_check(0, A_CNT, 0, 0);
    c1 = rdata;
    for (int k = 0; k < 5; k++) clock_step();
    drive_check(0, A_CNT, 0, 0);
    chk("cnt_diff5", rdata - c1, 32'd5);
    clock_step();
    drive_check(1, A_CNT, 32'h1234, 0);
    clock_step();
    drive_check(0, A_CNT, 0, 0);
    chk("cnt_after_wr", rdata, 32'd0);
    clock_step();
    drive_check(0, A_CNT, 0, 0);
    chk("cnt_plus1", rdata, 32'd1);
    clock_step();

    // Full FIFO with simultaneous push and pop.
    for (int k = 0; k < DEPTH; k++) begin
      drive_check(1, A_TXD, 32'ha1 + k, 0);
      clock_step();
    end
    drive_check(1, A_TXD, 32'h66, 1);
    got.delete();
    if (tx_valid) got.push_back(tx_data);
    clock_step();
    drive_check(0, A_TXS, 0, 0);
    chk("pushpop_still_full", rdata, 32'h2);
    clock_step();
    guard = 0;
    drive_check(0, A_TXS, 0, 1);
    while (tx_valid && guard < 20) begin
      got.push_back(tx_data);
      clock_step();
      drive_check(0, A_TXS, 0, 1);
      guard++;
    end
    chk("drain_bounded", {31'b0, tx_valid}, 32'h0);
    chk("drain_count", got.size(), 32'd5);
    chk("drain_last", {24'b0, (got.size() > 0) ? got[got.size()-1] : 8'h00}, 32'h66);
    chk("drain_txs", rdata, 32'h1);
    clock_step();

    // Async reset mid-transfer.
    drive_check(1, A_TXD, 32'h77, 0); clock_step();
    drive_check(1, A_TXD, 32'h88, 0); clock_step();
    drive_check(1, A_LED, 32'h00ff, 0); clock_step();
    drive_check(0, A_CNT, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst_led", {16'b0, led}, 32'h0);
    chk("arst_valid", {31'b0, tx_valid}, 32'h0);
    chk("arst_data", {24'b0, tx_data}, 32'h0);
    chk("arst_cnt", rdata, 32'h0);
    clock_step();
    clock_step();
    reset = 1'b0;
    drive_check(0, 32'h100, 0, 0);
    chk("arst_ram_kept", rdata, 32'h12345678);
    clock_step();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic        w;
      case ($urandom_range(0, 7))
        0: a = A_LED;
        1: a = A_CNT;
        2, 3: a = A_TXD;
        4: a = A_TXS;
        5: a = {16'hbfaf, 14'($urandom), 2'b00};
        default: a = 32'h200 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      endcase
      w = ($urandom_range(0, 2) == 0);
      if (a == A_CNT && $urandom_range(0, 3) != 0) w = 1'b0;
      drive_check(w, a, $urandom, 1'($urandom_range(0, 1)));
      clock_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
